// File: rtl/i2s_tdm_io_if.sv
// i2s_tdm_io_if -- bundle of the audio sample bus and codec pad signals
// around the TDM transceiver.
//   audio_tx  CHANNELS*BITS  TX samples, channel c at [c*BITS +: BITS]
//   audio_rx  CHANNELS*BITS  RX samples, same packing, updated once per frame
//   frame     1              one-clk frame boundary strobe
//   sclk      1              bit clock to codec
//   lrclk     1              frame sync, one SCLK period wide
//   dout      1              serial data to codec
//   din       1              serial data from codec
// Modports: master = transceiver side, slave = sample source / codec side.
`timescale 1ns/1ps

interface i2s_tdm_io_if #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 24
);
  logic [CHANNELS*BITS-1:0] audio_tx;
  logic [CHANNELS*BITS-1:0] audio_rx;
  logic                     frame;
  logic                     sclk;
  logic                     lrclk;
  logic                     dout;
  logic                     din;

  modport master (
    input  audio_tx, din,
    output audio_rx, frame, sclk, lrclk, dout
  );

  modport slave (
    output audio_tx, din,
    input  audio_rx, frame, sclk, lrclk, dout
  );
endinterface

// File: rtl/i2s_tdm_io.sv
// i2s_tdm_io -- PCM Format A (DSP mode) TDM master transceiver.
// Divides clk down to SCLK, emits a one-bit-wide LRCLK sync in the last bit
// period of each frame, serialises CHANNELS TX samples MSB first (each in a
// SLOT_BITS slot, zero padded) and deserialises the matching RX slots.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    i2s_tdm_io_if.master (audio_tx/audio_rx/frame/sclk/lrclk/dout/din)
// Build option: define I2S_TDM_LOOPBACK_EN to feed the RX path from the
// internal dout instead of the din pin.
`timescale 1ns/1ps

module i2s_tdm_io #(
  parameter int BITS      = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int SCLK_DIV  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  i2s_tdm_io_if.master  bus
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int SW         = CHANNELS * BITS;
  localparam int CW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW         = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] BIT_RST  = CW'(FRAME_BITS - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  if (BITS < 1 || BITS > SLOT_BITS || CHANNELS < 1 || CHANNELS > 8 || SCLK_DIV < 1)
  begin : g_param_err
    $error("i2s_tdm_io: illegal BITS/SLOT_BITS/CHANNELS/SCLK_DIV combination");
  end

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic [CW-1:0] bit_q, bit_d, bit_nxt;
  logic          lrclk_q, lrclk_d;
  logic          dout_q, dout_d;
  logic          frame_q, frame_d;
  logic [SW-1:0] tx_q, tx_d;       // TX shadow, latched at frame boundary
  logic [SW-1:0] rx_q, rx_d;       // RX shift registers, one BITS field per slot
  logic [SW-1:0] arx_q, arx_d;     // audio_rx holding register

  logic          div_wrap, rise, fall, boundary, rx_bit;
  int            cur_slot, cur_k;

  // Serial bit for every frame position, flattened so the fall event can pick
  // the next bit with a single index. Padding positions are tied to zero.
  logic [FRAME_BITS-1:0] tx_frame;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    for (genvar k = 0; k < SLOT_BITS; k++) begin : g_bit
      if (k < BITS) begin : g_data
        assign tx_frame[c*SLOT_BITS + k] = tx_q[c*BITS + BITS - 1 - k];
      end else begin : g_pad
        assign tx_frame[c*SLOT_BITS + k] = 1'b0;
      end
    end
  end

`ifdef I2S_TDM_LOOPBACK_EN
  assign rx_bit = dout_q;
`else
  assign rx_bit = bus.din;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path
    // leaves a value unassigned and no latch is inferred.
    div_wrap = (div_q == DIV_LAST);
    rise     = div_wrap & ~sclk_q;
    fall     = div_wrap &  sclk_q;
    bit_nxt  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    boundary = fall && (bit_nxt == '0);
    cur_slot = int'(bit_q) / SLOT_BITS;
    cur_k    = int'(bit_q) % SLOT_BITS;

    div_d    = div_wrap ? '0 : div_q + 1'b1;
    sclk_d   = sclk_q ^ div_wrap;
    bit_d    = bit_q;
    lrclk_d  = lrclk_q;
    dout_d   = dout_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    arx_d    = arx_q;
    frame_d  = boundary;

    // Rise event: capture into the slot currently on the wire, data bits only.
    for (int c = 0; c < CHANNELS; c++) begin
      if (rise && cur_slot == c && cur_k < BITS)
        rx_d[c*BITS +: BITS] = BITS'({rx_q[c*BITS +: BITS], rx_bit});
    end

    // Fall event: move to the next bit; sync marks the last bit of the frame.
    if (fall) begin
      bit_d   = bit_nxt;
      lrclk_d = (bit_nxt == BIT_LAST);
      dout_d  = tx_frame[bit_nxt];
    end

    // Frame boundary: the shadow is still the old frame, so the first bit
    // comes straight from the new audio_tx.
    if (boundary) begin
      tx_d   = bus.audio_tx;
      dout_d = bus.audio_tx[BITS-1];
      arx_d  = rx_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      sclk_q  <= 1'b0;
      bit_q   <= BIT_RST;
      lrclk_q <= 1'b0;
      dout_q  <= 1'b0;
      frame_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      arx_q   <= '0;
    end else begin
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      bit_q   <= bit_d;
      lrclk_q <= lrclk_d;
      dout_q  <= dout_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      arx_q   <= arx_d;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.lrclk    = lrclk_q;
  assign bus.dout     = dout_q;
  assign bus.frame    = frame_q;
  assign bus.audio_rx = arx_q;

endmodule

// File: tb/tb_i2s_tdm_io.sv
// tb_i2s_tdm_io -- self-checking bench for i2s_tdm_io (default build).
// A cycle-level reference model derives every pin from the elapsed clk count
// since reset release (bit position = (FRAME_BITS-2 + n/(2*SCLK_DIV)) mod
// FRAME_BITS), acts as the codec on din, and checks audio_rx at each strobe.
// On top of that: a vector table, a mid-frame audio_tx change, random free
// run, and a mid-frame reset.
`timescale 1ns/1ps

module tb_i2s_tdm_io;

  localparam int BITS      = 24;
  localparam int SLOT_BITS = 32;
  localparam int CHANNELS  = 2;
  localparam int SCLK_DIV  = 4;
  localparam int FB        = CHANNELS * SLOT_BITS;
  localparam int SW        = CHANNELS * BITS;
  localparam int FRAME_CLK = FB * 2 * SCLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tdm_io_if #(.CHANNELS(CHANNELS), .BITS(BITS)) bus ();

  i2s_tdm_io #(
    .BITS(BITS), .SLOT_BITS(SLOT_BITS), .CHANNELS(CHANNELS), .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_pos(input int n);
    return (FB - 2 + n / (2*SCLK_DIV)) % FB;
  endfunction

  function automatic logic exp_strobe(input int n);
    return (n > 0) && (n % (2*SCLK_DIV) == 0) && (exp_pos(n) == 0);
  endfunction

  function automatic logic tx_bit(input logic [SW-1:0] tx, input int p);
    int c, k;
    c = p / SLOT_BITS;
    k = p % SLOT_BITS;
    return (k < BITS) ? tx[c*BITS + BITS - 1 - k] : 1'b0;
  endfunction

  function automatic logic [FB-1:0] stream_of(input logic [SW-1:0] tx);
    logic [FB-1:0] s;
    for (int p = 0; p < FB; p++) s[FB-1-p] = tx_bit(tx, p);
    return s;
  endfunction

  function automatic logic [SW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SW-1:0];
  endfunction

  int            n, fidx;
  logic          boundary;
  logic [SW-1:0] tx_cur, model_tx, rx_cur, rx_next;
  logic [FB-1:0] stream_acc, last_stream;
  int            first_sclk, first_lr, first_frame;
  int            dut_frame_n, dut_lr_cnt;

  task automatic set_tx(input logic [SW-1:0] v);
    tx_cur       = v;
    bus.audio_tx = v;
  endtask

  task automatic release_reset();
    rst_n       = 1'b1;
    n           = 0;
    fidx        = 0;
    model_tx    = '0;
    first_sclk  = -1;
    first_lr    = -1;
    first_frame = -1;
    dut_frame_n = -1;
    dut_lr_cnt  = 0;
  endtask

  // One clk cycle: sample #1 after the edge, compare, then drive din as the codec.
  task automatic cycle();
    logic [3:0] exp_pins, act_pins;
    int p, c, k;
    @(posedge clk);
    #1;
    n++;
    p        = exp_pos(n);
    boundary = exp_strobe(n);
    if (boundary) begin
      if (fidx >= 1) check("audio_rx", bus.audio_rx, rx_cur);
      model_tx    = tx_cur;
      last_stream = stream_acc;
      rx_cur      = rx_next;
      fidx++;
    end
    exp_pins = {((n / SCLK_DIV) % 2) == 1, p == FB-1, boundary, tx_bit(model_tx, p)};
    act_pins = {bus.sclk, bus.lrclk, bus.frame, bus.dout};
    check($sformatf("pins@%0d", n), act_pins, exp_pins);
    stream_acc[FB-1-p] = bus.dout;

    if (bus.frame) begin
      if (dut_frame_n >= 0) begin
        check("frame_gap", n - dut_frame_n, FRAME_CLK);
        check("lrclk_len", dut_lr_cnt, 2*SCLK_DIV);
      end
      dut_frame_n = n;
      dut_lr_cnt  = 0;
    end
    if (bus.lrclk) dut_lr_cnt++;
    if (first_sclk  < 0 && bus.sclk)  first_sclk  = n;
    if (first_lr    < 0 && bus.lrclk) first_lr    = n;
    if (first_frame < 0 && bus.frame) first_frame = n;

    c = p / SLOT_BITS;
    k = p % SLOT_BITS;
    bus.din = (fidx >= 1 && k < BITS) ? rx_cur[c*BITS + BITS - 1 - k] : 1'($urandom());
  endtask

  task automatic run_to_boundary();
    int guard = 0;
    do begin
      cycle();
      guard++;
    end while (!boundary && guard < 2*FRAME_CLK);
    if (!boundary) check("boundary_timeout", 0, 1);
  endtask

  task automatic run_to_pos(input int pos, input logic need_sclk_hi);
    int guard = 0;
    do begin
      cycle();
      guard++;
    end while (!(exp_pos(n) == pos && (!need_sclk_hi || (n / SCLK_DIV) % 2 == 1))
               && guard < 2*FRAME_CLK);
  endtask

  task automatic check_start_timing();
    check("first_sclk_rise", first_sclk, 4);
    check("first_lrclk", first_lr, 8);
    check("first_frame", first_frame, 16);
  endtask

  typedef struct {
    logic [SW-1:0] tx;
    logic [SW-1:0] rx;
    logic [FB-1:0] exp_stream;
    logic [SW-1:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog n=%0d", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] a, b;

    vecs[0] = '{48'hABCDEF_123456, 48'h5A5A5A_A5A5A5, 64'h12345600_ABCDEF00, 48'h5A5A5A_A5A5A5};
    vecs[1] = '{48'hFFFFFF_FFFFFF, 48'h000000_FFFFFF, 64'hFFFFFF00_FFFFFF00, 48'h000000_FFFFFF};
    vecs[2] = '{48'h000001_800000, 48'h800001_000001, 64'h80000000_00000100, 48'h800001_000001};
    vecs[3] = '{48'h000000_000000, 48'hC3C3C3_3C3C3C, 64'h00000000_00000000, 48'hC3C3C3_3C3C3C};

    set_tx('0);
    bus.din    = 1'b0;
    rx_next    = '0;
    rx_cur     = '0;
    stream_acc = '0;
    n          = 0;
    fidx       = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pins", {bus.sclk, bus.lrclk, bus.frame, bus.dout}, 4'b0000);
    check("rst_audio_rx", bus.audio_rx, '0);

    // Start-up timing
    release_reset();
    run_to_boundary();
    check_start_timing();

    // Vector table: tx latched at the next boundary, streamed and looped back
    // by the codec model during the following frame.
    for (int i = 0; i < 4; i++) begin
      set_tx(vecs[i].tx);
      rx_next = vecs[i].rx;
      run_to_boundary();
      run_to_boundary();
      check($sformatf("tbl_stream%0d", i), last_stream, vecs[i].exp_stream);
      check($sformatf("tbl_rx%0d", i), bus.audio_rx, vecs[i].exp_rx);
    end

    // audio_tx change at slot 0 bit 20 must not touch the frame in flight
    a = 48'h0F0F0F_F0F0F0;
    b = 48'hE1E2E3_1D2D3D;
    set_tx(a);
    run_to_boundary();
    run_to_pos(20, 1'b0);
    set_tx(b);
    run_to_boundary();
    check("midframe_hold", last_stream, stream_of(a));
    run_to_boundary();
    check("midframe_next", last_stream, stream_of(b));

    // Random free run: ten frames, random RX slots and sporadic TX changes
    rx_next = rnd();
    for (int i = 0; i < 10*FRAME_CLK; i++) begin
      if ($urandom_range(0, 99) == 0) set_tx(rnd());
      cycle();
      if (boundary) rx_next = rnd();
    end

    // Mid-frame reset while sclk and dout are high
    set_tx('1);
    rx_next = 48'h5A5A5A_A5A5A5;
    run_to_boundary();
    run_to_boundary();
    run_to_pos(5, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_pins", {bus.sclk, bus.lrclk, bus.frame, bus.dout}, 4'b0000);
    check("midrst_audio_rx", bus.audio_rx, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_pins", {bus.sclk, bus.lrclk, bus.frame, bus.dout}, 4'b0000);
    release_reset();
    run_to_boundary();
    check_start_timing();
    rx_next = rnd();
    run_to_boundary();
    run_to_boundary();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
